// File: rtl/seq_muldiv_unit.sv
// seq_muldiv_unit
//   Multi-cycle multiply/divide unit. Iterates one bit per clock over a
//   WIDTH-bit datapath: shift-add multiply into a 2*WIDTH accumulator, or
//   restoring division producing quotient and remainder.
//
//   Optional feature macro: MULDIV_SIGNED_EN
//     defined   -> sgn=1 treats a/b as two's complement (magnitudes iterated,
//                  signs fixed up on the final load, no extra cycle)
//     undefined -> sgn ignored, all operations unsigned
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous reset, active-low
//   start      in   request, sampled in IDLE or DONE
//   op         in   0 = multiply, 1 = divide
//   sgn        in   signed request (only with MULDIV_SIGNED_EN)
//   a, b       in   WIDTH  multiplicand/dividend, multiplier/divisor
//   busy       out  high while iterating
//   done       out  one-cycle pulse, results valid
//   result_lo  out  WIDTH  product low half / quotient
//   result_hi  out  WIDTH  product high half / remainder
//   div_zero   out  divide with b == 0
//   zero       out  mul: product == 0, div: quotient == 0
module seq_muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_zero,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               op_r;
  logic               dz_r;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   mcand;   // multiplicand (mul) or divisor (div) magnitude
  logic [2*WIDTH-1:0] acc;     // mul: {partial product, remaining multiplier}
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;     // div: dividend shifting out, quotient shifting in
  logic               neg_q;
  logic               neg_r;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

`ifdef MULDIV_SIGNED_EN
  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
  assign a_mag = a;
  assign b_mag = b;
`endif

  // One iteration step for both datapaths.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_nx;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quo_nx;

  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    acc_nx  = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, mcand};
    // Remainder stays below the divisor, so bit WIDTH of the trial is its sign.
    rem_nx  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nx  = {quo[WIDTH-2:0], ~trial[WIDTH]};
  end

  // Final values with sign fixup applied on the RUN -> DONE load.
  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH-1:0]   quo_f;
  logic [WIDTH-1:0]   rem_f;

`ifdef MULDIV_SIGNED_EN
  assign prod_f = neg_q ? (~acc_nx + 1'b1) : acc_nx;
  assign quo_f  = neg_q ? (~quo_nx + 1'b1) : quo_nx;
  assign rem_f  = neg_r ? (~rem_nx + 1'b1) : rem_nx;
`else
  logic unused_neg;
  assign unused_neg = neg_q ^ neg_r;
  assign prod_f = acc_nx;
  assign quo_f  = quo_nx;
  assign rem_f  = rem_nx;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_r      <= 1'b0;
      dz_r      <= 1'b0;
      a_raw     <= '0;
      mcand     <= '0;
      acc       <= '0;
      rem       <= '0;
      quo       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      div_zero  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_r  <= op;
            a_raw <= a;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            dz_r  <= op && (b == '0);
            // Divide by zero runs a single pass so busy never rises.
            cnt   <= (op && (b == '0)) ? CW'(1) : CW'(WIDTH);
            if (op) begin
              quo   <= a_mag;
              rem   <= '0;
              mcand <= b_mag;
            end else begin
              acc   <= {{WIDTH{1'b0}}, b_mag};
              mcand <= a_mag;
            end
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          cnt <= cnt - 1'b1;
          // busy covers all but the final iteration cycle.
          busy <= (cnt != CW'(1));
          if (op_r) begin
            rem <= rem_nx;
            quo <= quo_nx;
          end else begin
            acc <= acc_nx;
          end
          if (cnt == CW'(1)) begin
            state <= DONE;
            done  <= 1'b1;
            if (dz_r) begin
              result_lo <= '1;
              result_hi <= a_raw;
              zero      <= 1'b0;
              div_zero  <= 1'b1;
            end else if (op_r) begin
              result_lo <= quo_f;
              result_hi <= rem_f;
              zero      <= (quo_f == '0);
              div_zero  <= 1'b0;
            end else begin
              result_lo <= prod_f[WIDTH-1:0];
              result_hi <= prod_f[2*WIDTH-1:WIDTH];
              zero      <= (prod_f == '0);
              div_zero  <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_muldiv_unit.sv
module tb_seq_muldiv_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic         sgn = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero, zero;
  logic [W-1:0] result_lo, result_hi;

  seq_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .sgn(sgn), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .div_zero(div_zero), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         zr;
    logic         dz;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Monitor: compare every completed result against the scoreboard.
  always @(negedge clk) begin
    if (rst && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result_lo", {16'd0, result_lo}, {16'd0, e.lo});
        chk("result_hi", {16'd0, result_hi}, {16'd0, e.hi});
        chk("zero", {31'd0, zero}, {31'd0, e.zr});
        chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
      end
    end
  end

  task automatic do_op(input logic o, input logic s, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic [W-1:0] elo,
                       input logic [W-1:0] ehi, input logic ez, input logic edz,
                       input int elat, input int ebusy, input bit noise);
    exp_t e;
    int bc;
    int lat;
    e.lo = elo; e.hi = ehi; e.zr = ez; e.dz = edz;
    q.push_back(e);
    @(negedge clk);
    op = o; sgn = s; a = va; b = vb; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bc = 0;
    lat = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk);
      #1;
      if (noise && cyc == 3) begin
        start = 1'b1; op = ~o; a = 16'h0005; b = 16'h0005;
      end
      if (noise && cyc == 6) start = 1'b0;
      if (busy) bc++;
      if (done) begin
        lat = cyc;
        break;
      end
    end
    if (lat == 0) chk("timeout", 32'd1, 32'd0);
    else begin
      chk("latency", lat, elat);
      chk("busy_cycles", bc, ebusy);
      @(posedge clk);
      #1;
      chk("done_pulse", {31'd0, done}, 32'd0);
      chk("hold_lo", {16'd0, result_lo}, {16'd0, elo});
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_lo", {16'd0, result_lo}, 32'd0);
    chk("rst_hi", {16'd0, result_hi}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_op(1'b0, 1'b0, 16'h0123, 16'h0045, 16'h4E6F, 16'h0000, 1'b0, 1'b0, 16, 15, 1'b0);
    do_op(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 16, 15, 1'b0);
    do_op(1'b0, 1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 16, 15, 1'b0);
    do_op(1'b1, 1'b0, 16'h00C9, 16'h0007, 16'h001C, 16'h0005, 1'b0, 1'b0, 16, 15, 1'b0);
    do_op(1'b1, 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b0, 1'b1, 1, 0, 1'b0);
    do_op(1'b1, 1'b0, 16'h0006, 16'h0003, 16'h0002, 16'h0000, 1'b0, 1'b0, 16, 15, 1'b0);
    do_op(1'b0, 1'b0, 16'h0010, 16'h0011, 16'h0110, 16'h0000, 1'b0, 1'b0, 16, 15, 1'b1);
`ifdef MULDIV_SIGNED_EN
    do_op(1'b1, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 16, 15, 1'b0);
    do_op(1'b0, 1'b1, 16'hFFFE, 16'h0003, 16'hFFFA, 16'hFFFF, 1'b0, 1'b0, 16, 15, 1'b0);
    do_op(1'b1, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b0, 16, 15, 1'b0);
`else
    do_op(1'b1, 1'b1, 16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001, 1'b0, 1'b0, 16, 15, 1'b0);
    do_op(1'b0, 1'b1, 16'hFFFE, 16'h0003, 16'hFFFA, 16'h0002, 1'b0, 1'b0, 16, 15, 1'b0);
`endif

    // Abort an operation mid-run; it must not produce a result.
    @(negedge clk);
    op = 1'b0; sgn = 1'b0; a = 16'h0123; b = 16'h0045; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_lo", {16'd0, result_lo}, 32'd0);
    chk("abort_hi", {16'd0, result_hi}, 32'd0);
    chk("abort_flags", {30'd0, zero, div_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_op(1'b1, 1'b0, 16'h0064, 16'h000A, 16'h000A, 16'h0000, 1'b0, 1'b0, 16, 15, 1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
